// File: rtl/aes_byte_loader.sv
// aes_byte_loader: packs a byte stream into an NBYTES-wide block for the AES
// round core. The first byte received lands in the most significant lane.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   FILL  | accepting bytes into lane byte_cnt; out_valid low
//   FULL  | block complete and held stable until out_ready; in_ready low
module aes_byte_loader #(
  parameter  int NBYTES = 16,
  localparam int CW     = $clog2(NBYTES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [8*NBYTES-1:0] out_block,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       byte_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [8*NBYTES-1:0] block_q, block_d;

  // State register: FSM state, byte count and lane storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

  // Next-state logic: lane write and count advance in FILL, release on
  // handshake in FULL; clr wins over both so an aborted block never escapes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i)) begin
              block_d[8*(NBYTES-1-i) +: 8] = in_data;
            end
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NBYTES - 1)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
    if (clr) begin
      state_d = FILL;
      cnt_d   = '0;
    end
  end

  // Outputs: handshake flags decode straight from the state flop, so there is
  // no combinational path from in_valid or out_ready.
  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == FULL);
    out_block = block_q;
    byte_cnt  = cnt_q;
  end

endmodule

// File: doc/aes_byte_loader.md
AES_BYTE_LOADER -- requirements
Module: aes_byte_loader

Interface
REQ-001 The block SHALL have parameter NBYTES, default 16, giving the number of bytes per assembled block; legal values are 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous abort; discards any partial or held block.
REQ-005 The block SHALL have port in_data, input, 8 bits: byte from the upstream byte register stage.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 The block SHALL have port out_block, output, 8*NBYTES bits: the assembled block, with first-received byte in bits [8*NBYTES-1 : 8*NBYTES-8].
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_block holds a complete block.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream round core accepts out_block this cycle.
REQ-011 The block SHALL have port byte_cnt, output, ceil(log2(NBYTES+1)) bits: the number of bytes currently held.

Function
REQ-012 The block SHALL implement a two-state FSM with states FILL and FULL.
REQ-013 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0; in FULL, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-014 A byte SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; on acceptance, in_data SHALL be written to byte lane byte_cnt (lane 0 = MSB byte) and byte_cnt SHALL increment by 1.
REQ-015 When the accepted byte is the NBYTES-th, the FSM SHALL go FILL->FULL on that same edge and byte_cnt SHALL equal NBYTES; out_valid SHALL be 1 in the cycle immediately following (latency 1 cycle from last byte to out_valid).
REQ-016 In FULL, out_block and out_valid SHALL hold stable until out_ready=1; the handshake SHALL complete on an edge with out_valid=1 and out_ready=1.
REQ-017 On handshake completion, the FSM SHALL return to FILL and byte_cnt SHALL return to 0; in_ready SHALL be 1 the following cycle, so sustained throughput is NBYTES+1 cycles per block.
REQ-018 in_data SHALL be ignored when in_valid=0 or in_ready=0; no lane or count change SHALL occur.
REQ-019 out_ready SHALL be ignored in FILL.
REQ-020 Byte lanes not yet written in the current block SHALL retain their previous values; out_block is only defined while out_valid=1.
REQ-021 byte_cnt SHALL never exceed NBYTES and SHALL never wrap.
REQ-022 clr=1 SHALL force FILL with byte_cnt=0 on the next edge, overriding a simultaneous byte acceptance or output handshake; lanes need not be cleared.
REQ-023 in_ready and out_valid SHALL be driven directly from state (registered), with no combinational path from in_valid or out_ready.

Reset
REQ-024 While rst=0, the block SHALL immediately hold state FILL, byte_cnt=0, out_valid=0, in_ready=1 and out_block all zero, independent of clk.
REQ-025 Reset asserted mid-fill or while FULL SHALL discard the partial or held block; after rst deasserts, the first accepted byte SHALL go to lane 0.
REQ-026 The first rising edge after rst deasserts SHALL be a normal operating edge.

Verification
REQ-027 Basic fill: stream bytes 00,11,22,...,ff with in_valid=1 continuously and out_ready=0 -> out_valid=1 the cycle after the 16th byte, out_block=00112233445566778899aabbccddeeff, byte_cnt=16, in_ready=0.
REQ-028 Back-pressure: hold FULL for 5 cycles, then set out_ready=1 for 1 cycle -> out_block is stable for all 5 cycles, FSM is in FILL with byte_cnt=0 on the next cycle, and the next stream 2b7e1516...09cf4f3c appears intact.
REQ-029 Gapped input: toggle in_valid every other cycle with garbage on in_data while in_valid=0 -> the assembled block contains only valid bytes and out_valid rises after 32 cycles.
REQ-030 Clear collision: assert clr on the same edge as the 16th byte -> out_valid stays 0 and byte_cnt=0; assert clr in FULL with out_ready=1 -> FILL with byte_cnt=0, no double handshake.
REQ-031 Async reset: pull rst low between clock edges after 7 bytes -> byte_cnt=0, out_valid=0 and in_ready=1 before the next edge; a subsequent 16-byte stream is assembled correctly from lane 0.
REQ-032 Parameter: NBYTES=4, bytes de,ad,be,ef -> out_block=32'hdeadbeef and byte_cnt width = 3 bits.
